// File: rtl/kernel_ctrl_if.sv
// Job descriptor handshake and configuration write bus for kernel_ctrl.
//   master: job issuer; drives the descriptor and job_val, observes job_rdy and the cfg bus.
//   slave : kernel_ctrl; accepts jobs and drives cfg_data/cfg_addr/cfg_valid.
interface kernel_ctrl_if #(
  parameter int unsigned CFG_DWIDTH = 32,
  parameter int unsigned CFG_AWIDTH = 5,
  parameter int unsigned MEM_AWIDTH = 16,
  parameter int unsigned PASS_WIDTH = 8
);

  logic [MEM_AWIDTH-1:0] job_wr_end;
  logic                  job_load;
  logic [MEM_AWIDTH-1:0] job_rd_start;
  logic [MEM_AWIDTH-1:0] job_rd_end;
  logic [PASS_WIDTH-1:0] job_passes;
  logic                  job_val;
  logic                  job_rdy;

  logic [CFG_DWIDTH-1:0] cfg_data;
  logic [CFG_AWIDTH-1:0] cfg_addr;
  logic                  cfg_valid;

  modport master (
    output job_wr_end, job_load, job_rd_start, job_rd_end, job_passes, job_val,
    input  job_rdy, cfg_data, cfg_addr, cfg_valid
  );

  modport slave (
    input  job_wr_end, job_load, job_rd_start, job_rd_end, job_passes, job_val,
    output job_rdy, cfg_data, cfg_addr, cfg_valid
  );

endinterface

// File: rtl/kernel_ctrl.sv
// kernel_ctrl: sequences one kernel job -- optional kernel load (config write, then
// counting stream beats into memory words) followed by a number of read passes
// (config write of the read window, then counting consumed kernel words per pass).
//
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous active-low reset
//   ker_str_beat - one accepted kernel stream beat (counted only in LOAD)
//   kernel_rdy   - one kernel word consumed (counted only in RUN)
//   bus          - kernel_ctrl_if.slave: job descriptor/handshake in, cfg writes out
//   busy         - job in progress
//   done         - single-cycle pulse at job completion
//   err          - single-cycle watchdog pulse
//
// Optional feature: define KERNEL_CTRL_TIMEOUT_EN to enable the LOAD/RUN watchdog
// (TIMEOUT cycles without a counted beat aborts the job with an err pulse).
// Without it, no watchdog logic exists and err is tied low.
module kernel_ctrl #(
  parameter int unsigned CFG_DWIDTH    = 32,
  parameter int unsigned CFG_AWIDTH    = 5,
  parameter int unsigned STR_KER_WIDTH = 64,
  parameter int unsigned KER_BUS_WIDTH = 1024,
  parameter int unsigned MEM_AWIDTH    = 16,
  parameter int unsigned PASS_WIDTH    = 8,
  parameter int unsigned TIMEOUT       = 4096,
  parameter int unsigned CFG_KER_WR    = 1,
  parameter int unsigned CFG_KER_RD    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ker_str_beat,
  input  logic        kernel_rdy,
  kernel_ctrl_if.slave bus,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned RATIO  = KER_BUS_WIDTH / STR_KER_WIDTH;
  localparam int unsigned BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned CNT_W  = MEM_AWIDTH + 1;

  // Elaboration-time guard on parameter combinations the datapath cannot represent.
  if (((KER_BUS_WIDTH % STR_KER_WIDTH) != 0) || (TIMEOUT == 0) ||
      (MEM_AWIDTH > (CFG_DWIDTH / 2))) begin : g_bad_params
    $error("kernel_ctrl: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CFG_WR = 3'd1,
    LOAD   = 3'd2,
    CFG_RD = 3'd3,
    RUN    = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [MEM_AWIDTH-1:0] wr_end_q, rd_start_q, rd_end_q;
  logic [PASS_WIDTH-1:0] passes_q;
  logic [BEAT_W-1:0]     beat_cnt_q;
  logic [CNT_W-1:0]      word_cnt_q;
  logic [CNT_W-1:0]      run_cnt_q;

  logic                  accept, beat_in, rdy_in;
  logic                  word_done, load_done, run_done, timeout;
  logic [MEM_AWIDTH-1:0] run_last_idx;
  logic [PASS_WIDTH-1:0] passes_left;

  logic                  cfg_valid_d;
  logic [CFG_AWIDTH-1:0] cfg_addr_d;
  logic [CFG_DWIDTH-1:0] cfg_data_d;
  logic [MEM_AWIDTH-1:0] wr_end_src, rd_start_src, rd_end_src;

  // Count strobes; inputs outside their owning state are ignored.
  assign accept       = (state_q == IDLE) && bus.job_val;
  assign beat_in      = (state_q == LOAD) && ker_str_beat;
  assign rdy_in       = (state_q == RUN) && kernel_rdy;
  assign word_done    = beat_in && (beat_cnt_q == BEAT_W'(RATIO - 1));
  assign load_done    = word_done && (word_cnt_q == {1'b0, wr_end_q});
  // Modular difference gives the wrap-around window length minus one.
  assign run_last_idx = rd_end_q - rd_start_q;
  assign run_done     = rdy_in && (run_cnt_q == {1'b0, run_last_idx});
  assign passes_left  = passes_q - PASS_WIDTH'(1);

`ifdef KERNEL_CTRL_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt_q;
  logic            wd_active;
  logic            err_q;

  assign wd_active = (state_q == LOAD) || (state_q == RUN);
  assign timeout   = wd_active && !beat_in && !rdy_in && (wd_cnt_q == WD_W'(TIMEOUT - 1));

  // Idle-cycle watchdog; restarts on every counted beat and outside LOAD/RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= timeout;
      if (!wd_active || beat_in || rdy_in || timeout) begin
        wd_cnt_q <= '0;
      end else begin
        wd_cnt_q <= wd_cnt_q + WD_W'(1);
      end
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // Next state and next-cycle cfg bus contents.
  always_comb begin
    state_d      = state_q;
    cfg_valid_d  = 1'b0;
    cfg_addr_d   = '0;
    cfg_data_d   = '0;
    // In IDLE the descriptor registers are still being loaded, so use the live fields.
    wr_end_src   = (state_q == IDLE) ? bus.job_wr_end   : wr_end_q;
    rd_start_src = (state_q == IDLE) ? bus.job_rd_start : rd_start_q;
    rd_end_src   = (state_q == IDLE) ? bus.job_rd_end   : rd_end_q;

    unique case (state_q)
      IDLE: begin
        if (bus.job_val) begin
          if (bus.job_load) begin
            state_d = CFG_WR;
          end else if (bus.job_passes != '0) begin
            state_d = CFG_RD;
          end else begin
            state_d = DONE;
          end
        end
      end
      CFG_WR: state_d = LOAD;
      LOAD: begin
        if (timeout) begin
          state_d = IDLE;
        end else if (load_done) begin
          state_d = (passes_q != '0) ? CFG_RD : DONE;
        end
      end
      CFG_RD: state_d = RUN;
      RUN: begin
        if (timeout) begin
          state_d = IDLE;
        end else if (run_done) begin
          state_d = (passes_left != '0) ? CFG_RD : DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == CFG_WR) begin
      cfg_valid_d                   = 1'b1;
      cfg_addr_d                    = CFG_AWIDTH'(CFG_KER_WR);
      cfg_data_d[MEM_AWIDTH-1:0]    = wr_end_src;
    end else if (state_d == CFG_RD) begin
      cfg_valid_d                   = 1'b1;
      cfg_addr_d                    = CFG_AWIDTH'(CFG_KER_RD);
      cfg_data_d[MEM_AWIDTH-1:0]    = rd_start_src;
      cfg_data_d[CFG_DWIDTH/2 +: MEM_AWIDTH] = rd_end_src;
    end
  end

  // State register and registered outputs (each a function of the next state).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      bus.cfg_valid <= 1'b0;
      bus.cfg_addr  <= '0;
      bus.cfg_data  <= '0;
      bus.job_rdy   <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      bus.cfg_valid <= cfg_valid_d;
      bus.cfg_addr  <= cfg_addr_d;
      bus.cfg_data  <= cfg_data_d;
      bus.job_rdy   <= (state_d == IDLE);
      busy          <= (state_d != IDLE);
      done          <= (state_d == DONE);
    end
  end

  // Descriptor capture on job accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_end_q   <= bus.job_wr_end;
      rd_start_q <= bus.job_rd_start;
      rd_end_q   <= bus.job_rd_end;
    end
  end

  // Beat, word, read and pass counters; each restarts when its count completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt_q <= '0;
      word_cnt_q <= '0;
      run_cnt_q  <= '0;
      passes_q   <= '0;
    end else if (accept) begin
      beat_cnt_q <= '0;
      word_cnt_q <= '0;
      run_cnt_q  <= '0;
      passes_q   <= bus.job_passes;
    end else begin
      if (beat_in) begin
        beat_cnt_q <= word_done ? '0 : beat_cnt_q + BEAT_W'(1);
      end
      if (word_done) begin
        word_cnt_q <= load_done ? '0 : word_cnt_q + CNT_W'(1);
      end
      if (rdy_in) begin
        run_cnt_q <= run_done ? '0 : run_cnt_q + CNT_W'(1);
      end
      if (run_done) begin
        passes_q <= passes_left;
      end
    end
  end

endmodule

// File: tb/tb_kernel_ctrl.sv
// Scoreboard bench for kernel_ctrl: directed jobs push their expected cfg writes and
// done/err pulses into a queue; a negedge monitor pops and compares each DUT event.
module tb_kernel_ctrl;

  localparam int unsigned CFG_DWIDTH = 32;
  localparam int unsigned CFG_AWIDTH = 5;
  localparam int unsigned MEM_AWIDTH = 16;
  localparam int unsigned PASS_WIDTH = 8;
  localparam int unsigned TIMEOUT    = 16;
  localparam int unsigned KER_WR     = 1;
  localparam int unsigned KER_RD     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ker_str_beat = 1'b0;
  logic kernel_rdy = 1'b0;
  logic busy, done, err;

  kernel_ctrl_if #(
    .CFG_DWIDTH(CFG_DWIDTH), .CFG_AWIDTH(CFG_AWIDTH),
    .MEM_AWIDTH(MEM_AWIDTH), .PASS_WIDTH(PASS_WIDTH)
  ) bus ();

  kernel_ctrl #(
    .CFG_DWIDTH(CFG_DWIDTH), .CFG_AWIDTH(CFG_AWIDTH), .STR_KER_WIDTH(64),
    .KER_BUS_WIDTH(1024), .MEM_AWIDTH(MEM_AWIDTH), .PASS_WIDTH(PASS_WIDTH),
    .TIMEOUT(TIMEOUT), .CFG_KER_WR(KER_WR), .CFG_KER_RD(KER_RD)
  ) dut (
    .clk(clk), .rst(rst), .ker_str_beat(ker_str_beat), .kernel_rdy(kernel_rdy),
    .bus(bus), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_CFG = 0, EV_DONE = 1, EV_ERR = 2} ev_kind_t;
  typedef struct {
    ev_kind_t              kind;
    logic [CFG_AWIDTH-1:0] addr;
    logic [CFG_DWIDTH-1:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  function automatic void push_cfg(input int unsigned addr, input logic [31:0] data);
    ev_t ev;
    ev.kind = EV_CFG;
    ev.addr = CFG_AWIDTH'(addr);
    ev.data = data;
    exp_q.push_back(ev);
  endfunction

  function automatic void push_ev(input ev_kind_t k);
    ev_t ev;
    ev.kind = k;
    ev.addr = '0;
    ev.data = '0;
    exp_q.push_back(ev);
  endfunction

  function automatic void mon_event(input ev_kind_t k);
    ev_t ev;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d addr 0x%0h data 0x%0h, expected no event",
               k, bus.cfg_addr, bus.cfg_data);
    end else begin
      ev = exp_q.pop_front();
      check("event_kind", 64'(k), 64'(ev.kind));
      if (k == EV_CFG && ev.kind == EV_CFG) begin
        check("cfg_addr", 64'(bus.cfg_addr), 64'(ev.addr));
        check("cfg_data", 64'(bus.cfg_data), 64'(ev.data));
      end
    end
  endfunction

  // Monitor: every DUT event on the sampled negedge is matched against the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.cfg_valid) mon_event(EV_CFG);
        else check("cfg_bus_zero_when_idle", {27'b0, bus.cfg_addr, bus.cfg_data}, 64'd0);
        if (done) mon_event(EV_DONE);
        if (err)  mon_event(EV_ERR);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish before 100000");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_job(input logic [15:0] we, input logic ld, input logic [15:0] rs,
                          input logic [15:0] re, input logic [7:0] ps, input logic keep_val);
    int n;
    n = 0;
    bus.job_wr_end   = we;
    bus.job_load     = ld;
    bus.job_rd_start = rs;
    bus.job_rd_end   = re;
    bus.job_passes   = ps;
    bus.job_val      = 1'b1;
    while (!bus.job_rdy && n < 200) begin
      tick();
      n++;
    end
    check("job_rdy_before_accept", 64'(bus.job_rdy), 64'd1);
    tick();
    if (!keep_val) bus.job_val = 1'b0;
  endtask

  task automatic beats(input int n);
    ker_str_beat = 1'b1;
    repeat (n) tick();
    ker_str_beat = 1'b0;
  endtask

  task automatic rdys(input int n);
    kernel_rdy = 1'b1;
    repeat (n) tick();
    kernel_rdy = 1'b0;
  endtask

  initial begin
    logic seen;
    bus.job_val = 1'b0;
    bus.job_wr_end = '0;
    bus.job_load = 1'b0;
    bus.job_rd_start = '0;
    bus.job_rd_end = '0;
    bus.job_passes = '0;

    // Reset state
    #2 rst = 1'b0;
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_cfg_valid", 64'(bus.cfg_valid), 64'd0);
    check("rst_cfg_bus", {27'b0, bus.cfg_addr, bus.cfg_data}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check("rst_release_job_rdy", 64'(bus.job_rdy), 64'd1);

    // Load 4 words (64 beats), two passes over 0..3
    push_cfg(KER_WR, 32'h0000_0003);
    push_cfg(KER_RD, 32'h0003_0000);
    push_cfg(KER_RD, 32'h0003_0000);
    push_ev(EV_DONE);
    send_job(16'd3, 1'b1, 16'd0, 16'd3, 8'd2, 1'b0);
    check("j1_busy_cfg_wr", 64'(busy), 64'd1);
    check("j1_job_rdy_busy", 64'(bus.job_rdy), 64'd0);
    tick();
    beats(63);
    check("j1_still_loading_63", 64'(bus.cfg_valid), 64'd0);
    beats(1);
    tick();
    rdys(4);
    tick();
    rdys(3);
    check("j1_no_done_before_8th", 64'(done), 64'd0);
    rdys(1);
    check("j1_done_after_8th_rdy", 64'(done), 64'd1);
    tick();
    check("j1_done_single", 64'(done), 64'd0);
    check("j1_idle_job_rdy", 64'(bus.job_rdy), 64'd1);

    // No load, zero passes: straight to DONE
    push_ev(EV_DONE);
    send_job(16'd0, 1'b0, 16'd0, 16'd0, 8'd0, 1'b0);
    seen = done;
    tick();
    seen = seen | done;
    check("j2_done_seen", 64'(seen), 64'd1);
    check("j2_back_idle", 64'(busy), 64'd0);

    // Wrapped read window 0xFFFE..0x0001 is 4 words
    push_cfg(KER_RD, 32'h0001_FFFE);
    push_ev(EV_DONE);
    send_job(16'd0, 1'b0, 16'hFFFE, 16'h0001, 8'd1, 1'b0);
    tick();
    rdys(3);
    check("j3_busy_after_3", 64'(busy), 64'd1);
    check("j3_no_done_after_3", 64'(done), 64'd0);
    rdys(1);
    check("j3_done_after_4", 64'(done), 64'd1);
    tick();

    // Reset during LOAD aborts; next job reloads from scratch
    push_cfg(KER_WR, 32'h0000_0001);
    send_job(16'd1, 1'b1, 16'd0, 16'd0, 8'd0, 1'b0);
    tick();
    beats(10);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_cfg_valid", 64'(bus.cfg_valid), 64'd0);
    check("abort_cfg_bus", {27'b0, bus.cfg_addr, bus.cfg_data}, 64'd0);
    check("abort_done", 64'(done), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    check("abort_release_idle", 64'(bus.job_rdy), 64'd1);
    push_cfg(KER_WR, 32'h0000_0001);
    push_ev(EV_DONE);
    send_job(16'd1, 1'b1, 16'd0, 16'd0, 8'd0, 1'b0);
    tick();
    beats(31);
    check("reload_busy_31", 64'(busy), 64'd1);
    check("reload_no_done_31", 64'(done), 64'd0);
    beats(1);
    check("reload_done_32", 64'(done), 64'd1);
    tick();

    // job_val held through a running job; second job taken right after DONE
    push_cfg(KER_RD, 32'h0001_0000);
    push_ev(EV_DONE);
    push_ev(EV_DONE);
    send_job(16'd0, 1'b0, 16'd0, 16'd1, 8'd1, 1'b1);
    bus.job_rd_end = 16'd0;
    bus.job_passes = 8'd0;
    check("hold_rdy_cfg_rd", 64'(bus.job_rdy), 64'd0);
    tick();
    check("hold_rdy_run", 64'(bus.job_rdy), 64'd0);
    rdys(2);
    check("hold_done_a", 64'(done), 64'd1);
    check("hold_rdy_done", 64'(bus.job_rdy), 64'd0);
    tick();
    check("hold_rdy_after_done", 64'(bus.job_rdy), 64'd1);
    tick();
    check("hold_done_b", 64'(done), 64'd1);
    bus.job_val = 1'b0;
    tick();
    check("hold_final_idle", 64'(busy), 64'd0);

`ifdef KERNEL_CTRL_TIMEOUT_EN
    // Watchdog: no beats in LOAD
    push_cfg(KER_WR, 32'h0000_0000);
    push_ev(EV_ERR);
    send_job(16'd0, 1'b1, 16'd0, 16'd0, 8'd0, 1'b0);
    tick();
    repeat (15) tick();
    check("wd_no_err_15", 64'(err), 64'd0);
    check("wd_busy_15", 64'(busy), 64'd1);
    tick();
    check("wd_err_16", 64'(err), 64'd1);
    check("wd_no_done", 64'(done), 64'd0);
    check("wd_idle", 64'(busy), 64'd0);
    tick();
    check("wd_err_single", 64'(err), 64'd0);
`else
    check("err_tied_low", 64'(err), 64'd0);
`endif

    repeat (3) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
